// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer
//   Captures one retired-instruction record per cycle into a small
//   first-word-fall-through FIFO for a trace consumer. The core is never
//   stalled: a retire that arrives while the FIFO is full and not popping is
//   dropped and counted. The next accepted record is then tagged with
//   trace_gap. Every retire gets a 32-bit sequence number, so ordering can be
//   rebuilt across drops.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   retire_valid, retire_*    retiring-instruction record (one per cycle max)
//   trace_valid/trace_ready   head-record handshake towards the consumer
//   trace_*                   head record fields (zero while trace_valid=0)
//   trace_seq, trace_gap      sequence number / drop-before-this marker
//   occupancy                 entries currently held
//   drop_count                saturating count of dropped retires
module retire_trace_buffer #(
   parameter int Depth          = 8,
   parameter int DropCountWidth = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      retire_valid,
   input  logic [31:0]               retire_pc,
   input  logic [31:0]               retire_instr,
   input  logic [6:0]                retire_opcode,
   input  logic [4:0]                retire_rd,
   input  logic [4:0]                retire_rs1,
   input  logic [4:0]                retire_rs2,
   input  logic [2:0]                retire_funct3,
   input  logic [6:0]                retire_funct7,
   input  logic [31:0]               retire_imm,
   output logic                      trace_valid,
   input  logic                      trace_ready,
   output logic [31:0]               trace_pc,
   output logic [31:0]               trace_instr,
   output logic [6:0]                trace_opcode,
   output logic [4:0]                trace_rd,
   output logic [4:0]                trace_rs1,
   output logic [4:0]                trace_rs2,
   output logic [2:0]                trace_funct3,
   output logic [6:0]                trace_funct7,
   output logic [31:0]               trace_imm,
   output logic [31:0]               trace_seq,
   output logic                      trace_gap,
   output logic [$clog2(Depth):0]    occupancy,
   output logic [DropCountWidth-1:0] drop_count
);

   localparam int AW = $clog2(Depth);
   localparam int PW = AW + 1;   // extra wrap bit separates full from empty

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  funct3;
      logic [6:0]  funct7;
      logic [31:0] imm;
      logic [31:0] seq;
      logic        gap;
   } rec_t;

   logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d, occ;
   logic [31:0]               seq_q, seq_d;
   logic                      gap_q, gap_d;
   logic [DropCountWidth-1:0] drop_q, drop_d;
   rec_t                      mem_q [Depth];
   rec_t                      wr_rec, head;
   logic                      empty, full, push, pop, drop;

   always_comb begin
      occ   = wptr_q - rptr_q;
      empty = (occ == '0);
      full  = (occ == PW'(Depth));
      pop   = !empty && trace_ready;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      push  = retire_valid && (!full || pop);
      drop  = retire_valid && !push;
   end

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      seq_d  = seq_q + 32'(retire_valid);   // counts dropped retires too
      gap_d  = gap_q;
      drop_d = drop_q;
      if (push) begin
         wptr_d = wptr_q + 1'b1;
         gap_d  = 1'b0;
      end
      if (pop)
         rptr_d = rptr_q + 1'b1;
      if (drop) begin
         gap_d = 1'b1;
         if (drop_q != '1)
            drop_d = drop_q + 1'b1;
      end
   end

   always_comb begin
      wr_rec = '{pc: retire_pc, instr: retire_instr, opcode: retire_opcode,
                 rd: retire_rd, rs1: retire_rs1, rs2: retire_rs2,
                 funct3: retire_funct3, funct7: retire_funct7,
                 imm: retire_imm, seq: seq_q, gap: gap_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
         seq_q  <= '0;
         gap_q  <= 1'b0;
         drop_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         seq_q  <= seq_d;
         gap_q  <= gap_d;
         drop_q <= drop_d;
      end
   end

   // Storage needs no reset: an entry is only observed after it was written.
   always_ff @(posedge clk) begin
      if (push && !rst)
         mem_q[wptr_q[AW-1:0]] <= wr_rec;
   end

   // Head is read straight from registered storage, so a record written in
   // cycle N is first visible in N+1. Gating by !empty keeps unwritten
   // storage from leaking onto the outputs.
   always_comb begin
      head = empty ? '0 : mem_q[rptr_q[AW-1:0]];
   end

   assign trace_valid  = !empty;
   assign trace_pc     = head.pc;
   assign trace_instr  = head.instr;
   assign trace_opcode = head.opcode;
   assign trace_rd     = head.rd;
   assign trace_rs1    = head.rs1;
   assign trace_rs2    = head.rs2;
   assign trace_funct3 = head.funct3;
   assign trace_funct7 = head.funct7;
   assign trace_imm    = head.imm;
   assign trace_seq    = head.seq;
   assign trace_gap    = head.gap;
   assign occupancy    = occ;
   assign drop_count   = drop_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: directed scenarios plus a random stream,
// checked against a queue-based model. A second instance with a 2-bit drop
// counter sees the same stimulus to exercise saturation.
module tb_retire_trace_buffer;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] seq;
      logic        gap;
   } mrec_t;

   logic  clk = 1'b0;
   logic  rs = 1'b1;
   logic  rv = 1'b0;
   logic  rdy = 1'b0;
   mrec_t rin = '0;

   logic        tv1, tv2;
   mrec_t       h1, h2;
   logic [3:0]  occ1, occ2;
   logic [15:0] dc1;
   logic [1:0]  dc2;

   int vectors = 0;
   int errs    = 0;

   // Reference model state
   mrec_t       mq[$];
   logic [31:0] mseq = 0;
   logic        mpend = 0;
   int          mdrops = 0;

   always #5 clk = ~clk;

   retire_trace_buffer #(.Depth(8), .DropCountWidth(16)) dut1 (
      .clk(clk), .rst(rs), .retire_valid(rv),
      .retire_pc(rin.pc), .retire_instr(rin.instr), .retire_opcode(rin.opcode),
      .retire_rd(rin.rd), .retire_rs1(rin.rs1), .retire_rs2(rin.rs2),
      .retire_funct3(rin.f3), .retire_funct7(rin.f7), .retire_imm(rin.imm),
      .trace_valid(tv1), .trace_ready(rdy),
      .trace_pc(h1.pc), .trace_instr(h1.instr), .trace_opcode(h1.opcode),
      .trace_rd(h1.rd), .trace_rs1(h1.rs1), .trace_rs2(h1.rs2),
      .trace_funct3(h1.f3), .trace_funct7(h1.f7), .trace_imm(h1.imm),
      .trace_seq(h1.seq), .trace_gap(h1.gap),
      .occupancy(occ1), .drop_count(dc1));

   retire_trace_buffer #(.Depth(8), .DropCountWidth(2)) dut2 (
      .clk(clk), .rst(rs), .retire_valid(rv),
      .retire_pc(rin.pc), .retire_instr(rin.instr), .retire_opcode(rin.opcode),
      .retire_rd(rin.rd), .retire_rs1(rin.rs1), .retire_rs2(rin.rs2),
      .retire_funct3(rin.f3), .retire_funct7(rin.f7), .retire_imm(rin.imm),
      .trace_valid(tv2), .trace_ready(rdy),
      .trace_pc(h2.pc), .trace_instr(h2.instr), .trace_opcode(h2.opcode),
      .trace_rd(h2.rd), .trace_rs1(h2.rs1), .trace_rs2(h2.rs2),
      .trace_funct3(h2.f3), .trace_funct7(h2.f7), .trace_imm(h2.imm),
      .trace_seq(h2.seq), .trace_gap(h2.gap),
      .occupancy(occ2), .drop_count(dc2));

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic mrec_t rand_rec();
      mrec_t r;
      r.pc = $urandom; r.instr = $urandom; r.opcode = 7'($urandom);
      r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
      r.f3 = 3'($urandom); r.f7 = 7'($urandom); r.imm = $urandom;
      r.seq = '0; r.gap = 1'b0;
      return r;
   endfunction

   // Model transition for one clock edge, straight from the buffer's rules.
   task automatic model_edge();
      bit    popped;
      mrec_t r;
      if (rs) begin
         mq.delete(); mseq = 0; mpend = 0; mdrops = 0;
         return;
      end
      popped = (mq.size() != 0) && rdy;
      if (popped) void'(mq.pop_front());
      if (rv) begin
         if (mq.size() < 8) begin
            r = rin; r.seq = mseq; r.gap = mpend;
            mq.push_back(r);
            mpend = 0;
         end else begin
            mdrops++;
            mpend = 1;
         end
         mseq++;
      end
   endtask

   task automatic check_all();
      int d2;
      d2 = (mdrops > 3) ? 3 : mdrops;
      chk("valid",  192'(tv1),  192'(mq.size() != 0));
      chk("occ",    192'(occ1), 192'(mq.size()));
      chk("drops",  192'(dc1),  192'(mdrops > 65535 ? 65535 : mdrops));
      chk("valid2", 192'(tv2),  192'(mq.size() != 0));
      chk("occ2",   192'(occ2), 192'(mq.size()));
      chk("drops2", 192'(dc2),  192'(d2));
      if (mq.size() != 0) begin
         chk("head",  192'(h1), 192'(mq[0]));
         chk("head2", 192'(h2), 192'(mq[0]));
      end
   endtask

   // Drive one cycle of inputs, advance the model at the edge, check at negedge.
   task automatic cyc(input logic v, input logic ready, input logic reset);
      rv = v; rdy = ready; rs = reset;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      // Reset state
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("rst_valid", 192'(tv1), 192'(0));
      chk("rst_gap",   192'(h1.gap), 192'(0));

      // Single retire: visible for exactly one cycle with seq 0
      rin = '0;
      rin.pc = 32'h8000_0000; rin.instr = 32'h0050_0093; rin.opcode = 7'h13;
      rin.rd = 5'd1; rin.imm = 32'd5;
      cyc(1, 1, 0);
      chk("t1_valid", 192'(tv1), 192'(1));
      chk("t1_pc",    192'(h1.pc), 192'(32'h8000_0000));
      chk("t1_seq",   192'(h1.seq), 192'(0));
      chk("t1_occ",   192'(occ1), 192'(1));
      cyc(0, 1, 0);
      chk("t1_gone",  192'(tv1), 192'(0));

      // Overflow with consumer stalled, then gap marking
      cyc(0, 0, 1);
      for (int i = 0; i < 10; i++) begin rin = rand_rec(); cyc(1, 0, 0); end
      chk("t2_occ",   192'(occ1), 192'(8));
      chk("t2_drops", 192'(dc1),  192'(2));
      for (int i = 0; i < 8; i++) cyc(0, 1, 0);
      rin = rand_rec(); cyc(1, 1, 0);
      chk("t2_seq10", 192'(h1.seq), 192'(10));
      chk("t2_gap1",  192'(h1.gap), 192'(1));
      rin = rand_rec(); cyc(1, 1, 0);
      chk("t2_seq11", 192'(h1.seq), 192'(11));
      chk("t2_gap0",  192'(h1.gap), 192'(0));

      // Full FIFO with simultaneous push and pop
      cyc(0, 0, 1);
      for (int i = 0; i < 8; i++) begin rin = rand_rec(); cyc(1, 0, 0); end
      rin = rand_rec(); cyc(1, 1, 0);
      chk("t3_occ",   192'(occ1), 192'(8));
      chk("t3_drops", 192'(dc1),  192'(0));
      for (int i = 0; i < 8; i++) cyc(0, 1, 0);

      // Reset mid-stream
      cyc(0, 0, 1);
      for (int i = 0; i < 11; i++) begin rin = rand_rec(); cyc(1, 0, 0); end
      for (int i = 0; i < 3; i++) cyc(0, 1, 0);
      chk("t4_occ5",   192'(occ1), 192'(5));
      chk("t4_drops3", 192'(dc1),  192'(3));
      rin = rand_rec(); cyc(1, 1, 1);
      chk("t4_occ0",   192'(occ1), 192'(0));
      chk("t4_valid0", 192'(tv1),  192'(0));
      chk("t4_drops0", 192'(dc1),  192'(0));
      rin = rand_rec(); cyc(1, 0, 0);
      chk("t4_seq0",   192'(h1.seq), 192'(0));

      // Drop counter saturation on the 2-bit instance
      cyc(0, 0, 1);
      for (int i = 0; i < 14; i++) begin rin = rand_rec(); cyc(1, 0, 0); end
      chk("t5_sat",  192'(dc2), 192'(3));
      chk("t5_wide", 192'(dc1), 192'(6));
      rin = rand_rec(); cyc(1, 0, 0);
      chk("t5_hold", 192'(dc2), 192'(3));

      // Random stream with random backpressure
      cyc(0, 0, 1);
      for (int i = 0; i < 400; i++) begin
         rin = rand_rec();
         cyc(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)), 0);
      end
      for (int i = 0; i < 10; i++) cyc(0, 1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
Captures one retired-instruction record per cycle from the core's writeback/retire point and buffers it in a small FIFO. The simulation trace consumer formats each record with the assembly package's string routine and prints it. The buffer never back-pressures the core. When full, it drops records, counts them, and flags the discontinuity on the next record it accepts. Each record carries a retire sequence number so the consumer can reconstruct ordering across drops.

Parameters:
Depth, 8, number of FIFO entries; power of two, minimum 2.
DropCountWidth, 16, width of the saturating drop counter.

Ports:
clk  input  1  core clock
rst  input  1  synchronous reset, active-high
retire_valid  input  1  one instruction retires this cycle
retire_pc  input  32  word_t; PC of retiring instruction
retire_instr  input  32  word_t; raw instruction word
retire_opcode  input  7  decoded opcode
retire_rd  input  5  destination register address
retire_rs1  input  5  source 1 address
retire_rs2  input  5  source 2 address
retire_funct3  input  3  funct3 field
retire_funct7  input  7  funct7 field
retire_imm  input  32  word_t; decoded, sign-extended immediate
trace_valid  output  1  head record available
trace_ready  input  1  consumer accepts head record
trace_pc, trace_instr, trace_opcode, trace_rd, trace_rs1, trace_rs2, trace_funct3, trace_funct7, trace_imm  output  (same widths as retire_*)  head record fields
trace_seq  output  32  retire sequence number of head record
trace_gap  output  1  one or more records were dropped immediately before this one
occupancy  output  $clog2(Depth)+1  entries currently held
drop_count  output  DropCountWidth  total dropped records, saturating

Behaviour:
- Reset (synchronous, rst=1 at posedge): read and write pointers 0, occupancy 0, seq counter 0, drop_count 0, pending-gap flag 0. Outputs: trace_valid=0, trace_gap=0, occupancy=0, drop_count=0. trace_* data fields are don't-care while trace_valid=0. Reset overrides any same-cycle push or pop, and mid-stream contents are discarded.
- Seq counter: 32-bit, increments by 1 on every cycle with retire_valid=1, whether the record is accepted or dropped. It wraps 0xFFFFFFFF→0. The record stores the pre-increment value, so the first retire after reset has seq 0.
- Pop: occurs when trace_valid && trace_ready. The read pointer advances, and the next entry appears on trace_* in the following cycle. trace_ready while empty is ignored.
- Push: occurs when retire_valid && (occupancy<Depth || pop this cycle). The full record is written at the write pointer and the pointer advances modulo Depth.
- Full and no pop: the retire is dropped. drop_count increments unless at all-ones (saturates). pending-gap is set to 1.
- Gap marking: an accepted push stores gap=pending-gap and clears pending-gap in the same cycle. Dropped records are never marked.
- Latency: first-word-fall-through with registered storage. A record pushed into an empty FIFO in cycle N shows trace_valid=1 with that record in cycle N+1, never in cycle N (no combinational bypass).
- Simultaneous push+pop: occupancy unchanged. When full this is legal and the push is accepted. When empty, the pop is not possible, so it is a push only.
- occupancy = number of stored entries. The full condition is occupancy==Depth, and pointers carry one extra wrap bit to distinguish full from empty.
- trace_* outputs hold stable while trace_valid=1 and trace_ready=0.
- No X propagation: storage contents are irrelevant until written, and trace_valid gates them.

Test Plan:
- Reset then single retire (pc=0x80000000, instr=0x00500093, opcode=0x13, rd=1, imm=5) in cycle 1, trace_ready=1 → trace_valid=1 in cycle 2 only, fields match, trace_seq=0, trace_gap=0, occupancy 1→0.
- trace_ready=0; 10 back-to-back retires, Depth=8 → occupancy=8, drop_count=2. Then ready=1 → 8 records with seq 0..7, all gap=0. Then one more retire (seq 10) → gap=1. Next retire (seq 11) → gap=0.
- Full FIFO, retire_valid=1 and trace_ready=1 in the same cycle → no drop, occupancy stays 8, drop_count unchanged, new record appears later in order.
- Backpressure hold: trace_ready toggled randomly while retires stream → every output record equals the golden model in order, and fields are stable while stalled.
- Reset asserted while occupancy=5 and drop_count=3 → next cycle occupancy=0, trace_valid=0, drop_count=0. Next retire has seq 0.
- Drop saturation with DropCountWidth=2: 6 drops → drop_count=3 and holds.
